// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ctrl
//  Description : Single-clock parametrised FIFO with occupancy count,
//                almost-full/almost-empty thresholds and sticky error flags.
//                Define FIFO_FWFT_EN for first-word fall-through read mode.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  Sync_Reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Wr_enable,
    input  logic                  Read_enable,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_afull  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] c_one    = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q,  count_d;
    logic                overflow_q,  overflow_d;
    logic                underflow_q, underflow_d;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx;

    // Flags decode the registered count directly, so they never lag the data.
    assign w_full   = (count_q == c_depth);
    assign w_empty  = (count_q == '0);
    assign w_rd_acc = Read_enable & ~w_empty;
    assign w_wr_acc = Wr_enable & (~w_full | w_rd_acc);
    assign w_rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];
    assign w_wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (Wr_enable & ~w_wr_acc);
        underflow_d = underflow_q | (Read_enable & ~w_rd_acc);
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_one;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + c_one;
        end
        if (w_wr_acc && !w_rd_acc) begin
            count_d = count_q + c_one;
        end else if (!w_wr_acc && w_rd_acc) begin
            count_d = count_q - c_one;
        end
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !Sync_Reset) begin
            mem_q[w_wr_idx] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = mem_q[w_rd_idx];
    assign data_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= w_rd_acc;
            if (w_rd_acc) begin
                data_out_q <= mem_q[w_rd_idx];
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (count_q >= c_afull);
    assign almost_empty = (count_q <= c_aempty);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_ctrl
//  Description : Randomised and directed bench for sync_fifo_ctrl with a
//                queue-based reference model and a read-data scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          Sync_Reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          Wr_enable = 1'b0;
    logic          Read_enable = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    sync_fifo_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk         (clk),
        .Sync_Reset  (Sync_Reset),
        .data_in     (data_in),
        .Wr_enable   (Wr_enable),
        .Read_enable (Read_enable),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stored words, sticky flags, last popped word.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] sb_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic          m_dv  = 1'b0;
    logic [DW-1:0] m_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic we, input logic re, input logic [DW-1:0] d,
                        input logic clr, input logic rst);
        logic rd_ok, wr_ok;
        int   sz;
        Wr_enable   = we;
        Read_enable = re;
        data_in     = d;
        clr_err     = clr;
        Sync_Reset  = rst;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dv   = 1'b0;
            m_last = '0;
        end else begin
            sz    = m_q.size();
            rd_ok = re && (sz > 0);
            wr_ok = we && ((sz < DEPTH) || rd_ok);
            if (rd_ok) begin
                m_last = m_q.pop_front();
                sb_q.push_back(m_last);
            end
            if (wr_ok) m_q.push_back(d);
            m_ovf = clr ? 1'b0 : (m_ovf | (we & ~wr_ok));
            m_udf = clr ? 1'b0 : (m_udf | (re & ~rd_ok));
            m_dv  = rd_ok;
        end
        #1;
        sz = m_q.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AET));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
        chk("data_valid",   32'(data_valid),   32'(m_dv));
        chk("data_out_hold",32'(data_out),     32'(m_last));
    endtask

    // Scoreboard monitor: every presented word must match the oldest expected pop.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_data: data_valid with data_out=%0h but no read expected at %0t",
                         data_out, $time);
            end else begin
                chk("rd_data", 32'(data_out), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        logic [DW-1:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 4; i++) step(1, 0, fill[i], 0, 0);
        step(1, 0, 8'h55, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0);

        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        for (int i = 0; i < 4; i++) step(1, 0, fill[i], 0, 0);
        step(1, 1, 8'hAA, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0);

        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 8'(i), 0, 0);
            step(0, 1, 8'h00, 0, 0);
        end

        for (int i = 0; i < 3; i++) step(1, 0, fill[i], 0, 0);
        step(1, 0, 8'h77, 0, 1);
        step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        step(0, 1, 8'h00, 1, 0);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 50,
                 8'($urandom),
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 2);
        end

        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
